// File: rtl/lr35902_pkg.sv
// lr35902_pkg: shared grant encoding and bank-width helper for the VRAM arbiter
package lr35902_pkg;
  typedef enum logic [1:0] {GNT_NONE, GNT_PPU, GNT_DMA, GNT_CPU} gnt_e;
  function automatic int bank_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction
  localparam int BANKS_DEF = 2;
  localparam int BANK_W = bank_w(BANKS_DEF);
endpackage

// File: rtl/lr35902_spram.sv
// lr35902_spram: clocked single-port RAM with registered read and no reset
module lr35902_spram #(
  parameter int DEPTH = 16384,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_adr,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  always_ff @(posedge i_clk)
    if (i_en) begin
      if (i_we) r_mem[i_adr] <= i_din;
      else r_dout <= r_mem[i_adr];
    end
  assign o_dout = r_dout;
endmodule

// File: rtl/lr35902_vram_arb.sv
// lr35902_vram_arb: banked VRAM with PPU/DMA/CPU arbitration, CPU lockout and VBK
module lr35902_vram_arb import lr35902_pkg::*; #(
  parameter int ADR_WIDTH  = 13,
  parameter int DATA_WIDTH = 8,
  parameter int BANKS      = 2,
  parameter int LOCK_DELAY = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_ppu_rd,
  input  logic [ADR_WIDTH-1:0]         i_ppu_adr,
  input  logic [bank_w(BANKS)-1:0]     i_ppu_bank,
  output logic [DATA_WIDTH-1:0]        o_ppu_dout,
  output logic                         o_ppu_valid,
  input  logic                         i_ppu_active,
  input  logic                         i_cpu_rd,
  input  logic                         i_cpu_wr,
  input  logic [ADR_WIDTH-1:0]         i_cpu_adr,
  input  logic [DATA_WIDTH-1:0]        i_cpu_din,
  output logic [DATA_WIDTH-1:0]        o_cpu_dout,
  output logic                         o_cpu_valid,
  input  logic                         i_vbk_wr,
  input  logic [DATA_WIDTH-1:0]        i_vbk_din,
  output logic [DATA_WIDTH-1:0]        o_vbk_dout,
  input  logic                         i_dma_wr,
  input  logic [ADR_WIDTH-1:0]         i_dma_adr,
  input  logic [DATA_WIDTH-1:0]        i_dma_din,
  output logic                         o_dma_ack,
  output logic                         o_cpu_locked
);
  localparam int BW    = bank_w(BANKS);
  localparam int CW    = (LOCK_DELAY < 1) ? 1 : $clog2(LOCK_DELAY + 1);
  localparam int DEPTH = BANKS << ADR_WIDTH;
  localparam int RAW   = $clog2(DEPTH);
  localparam logic [BW-1:0] BMASK = BW'(BANKS - 1);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;
  logic [BW-1:0]             r_vbk;
  logic [CW-1:0]             r_cnt;
  logic                      r_locked;
  logic                      r_ppu_v;
  logic                      r_cpu_v;
  logic                      r_cpu_ff;
  logic [DATA_WIDTH-1:0]     r_ppu_last;
  logic [DATA_WIDTH-1:0]     r_cpu_last;
  logic [DATA_WIDTH-1:0]     w_q;
  logic [CW-1:0]             w_cnt_nx;
  gnt_e                      w_gnt;
  logic                      w_cpu_rd;
  logic                      w_en;
  logic                      w_we;
  logic [BW+ADR_WIDTH-1:0]   w_adr;
  logic [DATA_WIDTH-1:0]     w_din;
  // A simultaneous rd+wr strobe is handled as a write, so it never yields read data.
  always_comb begin
    w_cpu_rd = i_cpu_rd & ~i_cpu_wr;
    w_gnt = i_ppu_rd ? GNT_PPU :
            i_dma_wr ? GNT_DMA :
            ((i_cpu_rd | i_cpu_wr) && !r_locked) ? GNT_CPU : GNT_NONE;
    w_adr = (w_gnt == GNT_PPU) ? {i_ppu_bank & BMASK, i_ppu_adr} :
            {r_vbk, (w_gnt == GNT_DMA) ? i_dma_adr : i_cpu_adr};
    w_din = (w_gnt == GNT_DMA) ? i_dma_din : i_cpu_din;
    w_en = w_gnt != GNT_NONE;
    w_we = (w_gnt == GNT_DMA) || (w_gnt == GNT_CPU && i_cpu_wr);
    w_cnt_nx = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
  end
  lr35902_spram #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_ram (
    .i_clk  (i_clk),
    .i_en   (w_en),
    .i_we   (w_we),
    .i_adr  (w_adr[RAW-1:0]),
    .i_din  (w_din),
    .o_dout (w_q)
  );
  // The counter is preloaded while mode 3 is active, so the first idle sample already counts.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_vbk      <= '0;
      r_cnt      <= '0;
      r_locked   <= 1'b0;
      r_ppu_v    <= 1'b0;
      r_cpu_v    <= 1'b0;
      r_cpu_ff   <= 1'b0;
      r_ppu_last <= '0;
      r_cpu_last <= '0;
    end else begin
      r_ppu_v  <= w_gnt == GNT_PPU;
      r_cpu_v  <= w_cpu_rd;
      r_cpu_ff <= w_gnt != GNT_CPU;
      if (r_ppu_v) r_ppu_last <= o_ppu_dout;
      if (r_cpu_v) r_cpu_last <= o_cpu_dout;
      if (i_vbk_wr) r_vbk <= i_vbk_din[BW-1:0] & BMASK;
      if (i_ppu_active) begin
        r_locked <= 1'b1;
        r_cnt    <= CW'(LOCK_DELAY);
      end else if (r_locked) begin
        r_cnt    <= w_cnt_nx;
        r_locked <= w_cnt_nx != '0;
      end
    end
  always_comb begin
    o_ppu_dout   = r_ppu_v ? w_q : r_ppu_last;
    o_ppu_valid  = r_ppu_v;
    o_cpu_dout   = r_cpu_v ? (r_cpu_ff ? ONES : w_q) : r_cpu_last;
    o_cpu_valid  = r_cpu_v;
    o_vbk_dout   = ~DATA_WIDTH'(BANKS - 1) | DATA_WIDTH'(r_vbk);
    o_dma_ack    = w_gnt == GNT_DMA;
    o_cpu_locked = r_locked;
  end
endmodule

// File: tb/tb_lr35902_vram_arb.sv
// tb_lr35902_vram_arb: vector table plus scoreboarded read checks for the VRAM arbiter
module tb_lr35902_vram_arb;
  logic        clk = 0;
  logic        reset = 0;
  logic        ppu_rd = 0, ppu_active = 0, cpu_rd = 0, cpu_wr = 0, vbk_wr = 0, dma_wr = 0;
  logic [12:0] ppu_adr = 0, cpu_adr = 0, dma_adr = 0;
  logic [0:0]  ppu_bank = 0;
  logic [7:0]  cpu_din = 0, vbk_din = 0, dma_din = 0;
  logic [7:0]  ppu_dout, cpu_dout, vbk_dout;
  logic        ppu_valid, cpu_valid, dma_ack, cpu_locked;
  int          n_cmp = 0, n_err = 0;
  logic [7:0]  ppu_q[$], cpu_q[$];
  logic [7:0]  ppu_last = 0, cpu_last = 0;
  typedef struct {
    int          op;
    logic        bank;
    logic [12:0] adr;
    logic [7:0]  d;
    logic        vw;
    logic [7:0]  vd;
    logic [7:0]  ev;
  } vec_t;
  vec_t tbl[17];
  lr35902_vram_arb dut (
    .i_clk(clk), .i_reset(reset),
    .i_ppu_rd(ppu_rd), .i_ppu_adr(ppu_adr), .i_ppu_bank(ppu_bank),
    .o_ppu_dout(ppu_dout), .o_ppu_valid(ppu_valid), .i_ppu_active(ppu_active),
    .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr), .i_cpu_adr(cpu_adr), .i_cpu_din(cpu_din),
    .o_cpu_dout(cpu_dout), .o_cpu_valid(cpu_valid),
    .i_vbk_wr(vbk_wr), .i_vbk_din(vbk_din), .o_vbk_dout(vbk_dout),
    .i_dma_wr(dma_wr), .i_dma_adr(dma_adr), .i_dma_din(dma_din), .o_dma_ack(dma_ack),
    .o_cpu_locked(cpu_locked)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!reset) assert (!(cpu_rd && cpu_wr)) else $error("illegal cpu_rd+cpu_wr");
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic monitor();
    logic [7:0] e;
    chk("ppu_valid", ppu_valid, ppu_q.size() != 0);
    if (ppu_q.size() != 0) begin
      e = ppu_q.pop_front();
      if (ppu_valid) chk("ppu_dout", ppu_dout, e);
      ppu_last = e;
    end else chk("ppu_hold", ppu_dout, ppu_last);
    chk("cpu_valid", cpu_valid, cpu_q.size() != 0);
    if (cpu_q.size() != 0) begin
      e = cpu_q.pop_front();
      if (cpu_valid) chk("cpu_dout", cpu_dout, e);
      cpu_last = e;
    end else chk("cpu_hold", cpu_dout, cpu_last);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    monitor();
    ppu_rd = 0; cpu_rd = 0; cpu_wr = 0; vbk_wr = 0;
  endtask
  task automatic ppu_read(input logic b, input logic [12:0] a, input logic [7:0] e);
    ppu_rd = 1; ppu_bank = b; ppu_adr = a; ppu_q.push_back(e);
  endtask
  task automatic cpu_read(input logic [12:0] a, input logic [7:0] e);
    cpu_rd = 1; cpu_adr = a; cpu_q.push_back(e);
  endtask
  task automatic cpu_write(input logic [12:0] a, input logic [7:0] d);
    cpu_wr = 1; cpu_adr = a; cpu_din = d;
  endtask
  initial begin
    tbl = '{
      '{1, 1'b0, 13'h0010, 8'h5A, 1'b0, 8'h00, 8'hFE},
      '{2, 1'b0, 13'h0010, 8'h5A, 1'b0, 8'h00, 8'hFE},
      '{0, 1'b0, 13'h0000, 8'h00, 1'b1, 8'h01, 8'hFF},
      '{1, 1'b0, 13'h0010, 8'hA5, 1'b0, 8'h00, 8'hFF},
      '{3, 1'b0, 13'h0010, 8'h5A, 1'b0, 8'h00, 8'hFF},
      '{3, 1'b1, 13'h0010, 8'hA5, 1'b0, 8'h00, 8'hFF},
      '{2, 1'b0, 13'h0010, 8'hA5, 1'b0, 8'h00, 8'hFF},
      '{0, 1'b0, 13'h0000, 8'h00, 1'b1, 8'hFE, 8'hFE},
      '{2, 1'b0, 13'h0010, 8'h5A, 1'b0, 8'h00, 8'hFE},
      '{1, 1'b0, 13'h1FFF, 8'h3C, 1'b0, 8'h00, 8'hFE},
      '{1, 1'b0, 13'h1FFF, 8'hC3, 1'b1, 8'h03, 8'hFF},
      '{1, 1'b0, 13'h1FFF, 8'h77, 1'b0, 8'h00, 8'hFF},
      '{3, 1'b0, 13'h1FFF, 8'hC3, 1'b0, 8'h00, 8'hFF},
      '{3, 1'b1, 13'h1FFF, 8'h77, 1'b0, 8'h00, 8'hFF},
      '{2, 1'b0, 13'h1FFF, 8'h77, 1'b0, 8'h00, 8'hFF},
      '{0, 1'b0, 13'h0000, 8'h00, 1'b1, 8'h00, 8'hFE},
      '{2, 1'b0, 13'h1FFF, 8'hC3, 1'b0, 8'h00, 8'hFE}
    };
    #2 reset = 1;
    #20;
    chk("rst_ppu_dout", ppu_dout, 8'h00);
    chk("rst_cpu_dout", cpu_dout, 8'h00);
    chk("rst_ppu_valid", ppu_valid, 1'b0);
    chk("rst_cpu_valid", cpu_valid, 1'b0);
    chk("rst_vbk", vbk_dout, 8'hFE);
    chk("rst_locked", cpu_locked, 1'b0);
    chk("rst_dma_ack", dma_ack, 1'b0);
    @(negedge clk) reset = 0;
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].vw) begin vbk_wr = 1; vbk_din = tbl[i].vd; end
      if (tbl[i].op == 1) cpu_write(tbl[i].adr, tbl[i].d);
      if (tbl[i].op == 2) cpu_read(tbl[i].adr, tbl[i].d);
      if (tbl[i].op == 3) ppu_read(tbl[i].bank, tbl[i].adr, tbl[i].d);
      step();
      chk($sformatf("vec%0d_vbk", i), vbk_dout, tbl[i].ev);
    end
    // lockout: reads return all ones, writes are dropped, release after two idle clocks
    ppu_active = 1; step();
    chk("lock_set", cpu_locked, 1'b1);
    cpu_read(13'h0010, 8'hFF); step();
    cpu_write(13'h0010, 8'h00); step();
    ppu_active = 0; step();
    chk("lock_cd1", cpu_locked, 1'b1);
    step();
    chk("lock_clr", cpu_locked, 1'b0);
    cpu_read(13'h0010, 8'h5A); step();
    // countdown restart
    ppu_active = 1; step();
    ppu_active = 0; step();
    chk("rst_cd_a", cpu_locked, 1'b1);
    ppu_active = 1; step();
    ppu_active = 0; step();
    chk("rst_cd_b", cpu_locked, 1'b1);
    step();
    chk("rst_cd_clr", cpu_locked, 1'b0);
    // DMA held off by PPU read
    dma_wr = 1; dma_adr = 13'h0020; dma_din = 8'h99;
    ppu_read(1'b0, 13'h0010, 8'h5A);
    #1 chk("dma_hold", dma_ack, 1'b0);
    step();
    #1 chk("dma_ack", dma_ack, 1'b1);
    step();
    dma_wr = 0;
    cpu_read(13'h0020, 8'h99); step();
    // DMA while locked
    ppu_active = 1; step();
    dma_wr = 1; dma_adr = 13'h0030; dma_din = 8'h42;
    #1 chk("dma_locked_ack", dma_ack, 1'b1);
    step();
    dma_wr = 0;
    ppu_read(1'b0, 13'h0030, 8'h42); step();
    ppu_active = 0; step(); step();
    chk("lock_clr2", cpu_locked, 1'b0);
    // three-way contention
    dma_wr = 1; dma_adr = 13'h0040; dma_din = 8'h11;
    ppu_read(1'b1, 13'h0010, 8'hA5);
    cpu_read(13'h0010, 8'hFF);
    #1 chk("tri_dma_hold", dma_ack, 1'b0);
    step();
    #1 chk("tri_dma_ack", dma_ack, 1'b1);
    step();
    dma_wr = 0;
    ppu_read(1'b0, 13'h0040, 8'h11); step();
    // reset during countdown with a read in flight
    ppu_active = 1; step();
    ppu_active = 0; step();
    chk("mid_locked", cpu_locked, 1'b1);
    cpu_rd = 1; cpu_adr = 13'h0010;
    @(posedge clk); #1;
    chk("mid_pend_valid", cpu_valid, 1'b1);
    chk("mid_pend_dout", cpu_dout, 8'hFF);
    reset = 1; cpu_rd = 0;
    #1;
    chk("mid_rst_valid", cpu_valid, 1'b0);
    chk("mid_rst_locked", cpu_locked, 1'b0);
    chk("mid_rst_dout", cpu_dout, 8'h00);
    chk("mid_rst_vbk", vbk_dout, 8'hFE);
    @(negedge clk) reset = 0;
    cpu_last = 0; ppu_last = 0;
    cpu_read(13'h0010, 8'h5A); step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
